alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue ALU front end.
// A request is decoded and latched in IDLE. The external ALU result is captured
// in EXEC. The response is held in RESP until the consumer takes it.
// Build option: define ALU_ISSUE_ILLEGAL_TRAP_EN to trap illegal opcode/funct
// pairs. A trapped request returns out_err=1, out_result=0 and out_zero=1
// instead of the ALU output.
module alu_issue_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [15:0]       imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_branch_taken,
  output logic              out_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // No legal code decodes to 1111, so alu_op alone marks an illegal request.
  localparam logic [3:0] ILLEGAL_OP = 4'b1111;

  logic [1:0]        state;
  logic              dec_legal;
  logic [3:0]        dec_op;
  logic [DATA_W-1:0] dec_b;
  logic [1:0]        dec_br;
  logic [1:0]        br_p0;   // {bne, beq} of the request in flight

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext_imm(input logic [15:0] v);
    return {{(DATA_W-16){1'b0}}, v};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);

  // Decode the presented request into ALU operation, B operand and branch kind.
  always_comb begin
    dec_legal = 1'b1;
    dec_op    = ILLEGAL_OP;
    dec_b     = rt_val;
    dec_br    = 2'b00;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20:   dec_op = 4'b0000;
          6'h22:   dec_op = 4'b0001;
          6'h2A:   dec_op = 4'b0010;
          6'h2B:   dec_op = 4'b0011;
          6'h24:   dec_op = 4'b0100;
          6'h25:   dec_op = 4'b0101;
          6'h26:   dec_op = 4'b0110;
          6'h27:   dec_op = 4'b0111;
          6'h02:   dec_op = 4'b1100;
          6'h00:   dec_op = 4'b1101;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin dec_op = 4'b0000; dec_b = sext_imm(imm); end
      6'h0A: begin dec_op = 4'b0010; dec_b = sext_imm(imm); end
      6'h0B: begin dec_op = 4'b0011; dec_b = sext_imm(imm); end
      6'h0C: begin dec_op = 4'b0100; dec_b = zext_imm(imm); end
      6'h0D: begin dec_op = 4'b0101; dec_b = zext_imm(imm); end
      6'h0E: begin dec_op = 4'b0110; dec_b = zext_imm(imm); end
      6'h04: begin dec_op = 4'b0001; dec_br = 2'b01; end
      6'h05: begin dec_op = 4'b0001; dec_br = 2'b10; end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_op = ILLEGAL_OP;
      dec_br = 2'b00;
    end
  end

  // Control: IDLE -> EXEC on accept, EXEC -> RESP after one cycle, RESP -> IDLE on out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state <= EXEC;
        EXEC:    state <= RESP;
        RESP:    if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Issue stage: operands and op are latched on accept and held until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= 4'b0000;
      br_p0  <= 2'b00;
    end else if (state == IDLE && in_valid) begin
      alu_a  <= rs_val;
      alu_b  <= dec_b;
      alu_op <= dec_op;
      br_p0  <= dec_br;
    end
  end

  // Response stage: capture the ALU output in EXEC; hold it through RESP and IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_result       <= '0;
      out_zero         <= 1'b0;
      out_branch_taken <= 1'b0;
      out_err          <= 1'b0;
    end else if (state == EXEC) begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      if (alu_op == ILLEGAL_OP) begin
        out_result       <= '0;
        out_zero         <= 1'b1;
        out_branch_taken <= 1'b0;
        out_err          <= 1'b1;
      end else begin
        out_result       <= alu_result;
        out_zero         <= alu_zero;
        out_branch_taken <= (br_p0[0] & alu_zero) | (br_p0[1] & ~alu_zero);
        out_err          <= 1'b0;
      end
`else
      out_result       <= alu_result;
      out_zero         <= alu_zero;
      out_branch_taken <= (br_p0[0] & alu_zero) | (br_p0[1] & ~alu_zero);
      out_err          <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed scenarios plus randomized requests
// checked against a table-driven reference model and a behavioural ALU stub.
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk, reset, in_valid, in_ready;
  logic [5:0]  opcode, funct;
  logic [31:0] rs_val, rt_val;
  logic [15:0] imm;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero, out_valid, out_ready, out_zero, out_branch_taken, out_err;
  logic [31:0] out_result;

  int n_cmp = 0;
  int n_mis = 0;

  // bsrc: 0 = rt_val, 1 = sign-extended imm, 2 = zero-extended imm
  typedef struct packed {
    logic [5:0] opc;
    logic [5:0] fn;
    logic [3:0] op;
    logic [1:0] bsrc;
  } ent_t;
  ent_t tbl [18];

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_zero(alu_zero), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_branch_taken(out_branch_taken), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h3: return (a < b) ? 32'd1 : 32'd0;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return a ^ b;
      4'h7: return ~(a | b);
      4'hC: return a >> b[4:0];
      4'hD: return a << b[4:0];
      default: return a + b + 32'd1;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_model(alu_op, alu_a, alu_b);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: table lookup for the code, arithmetic extension of imm, ALU stub for the result.
  task automatic ref_predict(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [15:0] im,
                             output bit legal, output logic [3:0] op, output logic [31:0] b,
                             output logic [31:0] res, output logic zero, output logic br,
                             output logic err);
    legal = 1'b0;
    op    = 4'hF;
    b     = rt;
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].opc == opc && (opc != 6'h00 || tbl[i].fn == fn)) begin
        legal = 1'b1;
        op    = tbl[i].op;
        if (tbl[i].bsrc == 2'd1)      b = im[15] ? (32'(im) + 32'hFFFF_0000) : 32'(im);
        else if (tbl[i].bsrc == 2'd2) b = 32'(im);
      end
    end
    res  = alu_model(op, rs, b);
    zero = (res == 32'd0);
    br   = (legal && opc == 6'h04) ? zero : (legal && opc == 6'h05) ? !zero : 1'b0;
    err  = 1'b0;
    if (!legal && TRAP) begin
      res  = 32'd0;
      zero = 1'b1;
      br   = 1'b0;
      err  = 1'b1;
    end
  endtask

  task automatic do_txn(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [15:0] im, input int stall);
    bit          legal;
    logic [3:0]  e_op;
    logic [31:0] e_b, e_res;
    logic        e_zero, e_br, e_err;
    int          guard;
    ref_predict(opc, fn, rs, rt, im, legal, e_op, e_b, e_res, e_zero, e_br, e_err);
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    chk1("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; opcode = opc; funct = fn; rs_val = rs; rt_val = rt; imm = im;
    step();
    in_valid = 1'b0;
    opcode = 6'($urandom); funct = 6'($urandom); rs_val = $urandom; rt_val = $urandom; imm = 16'($urandom);
    chk32("alu_op", {28'd0, alu_op}, {28'd0, e_op});
    if (legal) begin
      chk32("alu_a", alu_a, rs);
      chk32("alu_b", alu_b, e_b);
    end
    chk1("in_ready_exec", in_ready, 1'b0);
    chk1("lat_exec_nvalid", out_valid, 1'b0);
    step();
    chk1("lat_resp_valid", out_valid, 1'b1);
    chk32("out_result", out_result, e_res);
    chk1("out_zero", out_zero, e_zero);
    chk1("out_branch", out_branch_taken, e_br);
    chk1("out_err", out_err, e_err);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1; opcode = 6'h00; funct = 6'h20; rs_val = $urandom; rt_val = $urandom;
      step();
      chk1("stall_valid", out_valid, 1'b1);
      chk1("stall_in_ready", in_ready, 1'b0);
      chk32("stall_result", out_result, e_res);
      chk1("stall_zero", out_zero, e_zero);
      chk1("stall_branch", out_branch_taken, e_br);
      chk1("stall_err", out_err, e_err);
      chk32("stall_alu_op", {28'd0, alu_op}, {28'd0, e_op});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk1("release_nvalid", out_valid, 1'b0);
    chk1("release_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    tbl = '{
      '{6'h00, 6'h20, 4'h0, 2'd0}, '{6'h00, 6'h22, 4'h1, 2'd0}, '{6'h00, 6'h2A, 4'h2, 2'd0},
      '{6'h00, 6'h2B, 4'h3, 2'd0}, '{6'h00, 6'h24, 4'h4, 2'd0}, '{6'h00, 6'h25, 4'h5, 2'd0},
      '{6'h00, 6'h26, 4'h6, 2'd0}, '{6'h00, 6'h27, 4'h7, 2'd0}, '{6'h00, 6'h02, 4'hC, 2'd0},
      '{6'h00, 6'h00, 4'hD, 2'd0}, '{6'h08, 6'h00, 4'h0, 2'd1}, '{6'h0A, 6'h00, 4'h2, 2'd1},
      '{6'h0B, 6'h00, 4'h3, 2'd1}, '{6'h0C, 6'h00, 4'h4, 2'd2}, '{6'h0D, 6'h00, 4'h5, 2'd2},
      '{6'h0E, 6'h00, 4'h6, 2'd2}, '{6'h04, 6'h00, 4'h1, 2'd0}, '{6'h05, 6'h00, 4'h1, 2'd0}
    };
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 6'h00; funct = 6'h00; rs_val = 32'd0; rt_val = 32'd0; imm = 16'd0;

    // Reset values
    step();
    step();
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_out_result", out_result, 32'd0);
    chk1("rst_out_zero", out_zero, 1'b0);
    chk1("rst_out_branch", out_branch_taken, 1'b0);
    chk1("rst_out_err", out_err, 1'b0);
    chk32("rst_alu_a", alu_a, 32'd0);
    chk32("rst_alu_b", alu_b, 32'd0);
    chk32("rst_alu_op", {28'd0, alu_op}, 32'd0);
    reset = 1'b0;

    // add, accepted on the first edge after reset release
    do_txn(6'h00, 6'h20, 32'd5, 32'd7, 16'd0, 0);
    chk32("add_result", out_result, 32'd12);
    chk32("add_alu_op", {28'd0, alu_op}, 32'd0);
    chk1("add_zero", out_zero, 1'b0);

    // addi / ori immediate extension
    do_txn(6'h08, 6'h3F, 32'h10, 32'h1234, 16'hFFFF, 0);
    chk32("addi_alu_b", alu_b, 32'hFFFF_FFFF);
    chk32("addi_result", out_result, 32'h0000_000F);
    do_txn(6'h0D, 6'h00, 32'h10, 32'h1234, 16'hFFFF, 0);
    chk32("ori_alu_b", alu_b, 32'h0000_FFFF);

    // beq / bne with equal operands
    do_txn(6'h04, 6'h00, 32'd3, 32'd3, 16'd0, 0);
    chk1("beq_zero", out_zero, 1'b1);
    chk1("beq_taken", out_branch_taken, 1'b1);
    do_txn(6'h05, 6'h00, 32'd3, 32'd3, 16'd0, 0);
    chk1("bne_taken", out_branch_taken, 1'b0);

    // backpressure
    do_txn(6'h00, 6'h22, 32'd100, 32'd1, 16'd0, 4);

    // illegal code
    do_txn(6'h3F, 6'h00, 32'd9, 32'd4, 16'd0, 1);
    chk1("illegal_err", out_err, TRAP);
    chk32("illegal_alu_op", {28'd0, alu_op}, 32'hF);
    if (TRAP) chk32("illegal_result", out_result, 32'd0);

    // reset while in EXEC
    in_valid = 1'b1; opcode = 6'h00; funct = 6'h25; rs_val = 32'hF0; rt_val = 32'h0F;
    step();
    in_valid = 1'b0;
    chk1("mid_in_exec", in_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk32("mid_rst_out_result", out_result, 32'd0);
    chk1("mid_rst_out_zero", out_zero, 1'b0);
    chk1("mid_rst_out_branch", out_branch_taken, 1'b0);
    chk1("mid_rst_out_err", out_err, 1'b0);
    chk32("mid_rst_alu_a", alu_a, 32'd0);
    chk32("mid_rst_alu_b", alu_b, 32'd0);
    chk32("mid_rst_alu_op", {28'd0, alu_op}, 32'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk1("mid_no_resp", out_valid, 1'b0);
    end
    do_txn(6'h00, 6'h26, 32'hFF00, 32'h0FF0, 16'd0, 0);
    chk32("after_rst_result", out_result, 32'hF0F0);

    // randomized requests
    for (int t = 0; t < 40; t++) begin
      logic [5:0] ro, rf;
      int pick;
      pick = int'($urandom_range(0, 9));
      if (pick < 7) begin
        int idx;
        idx = int'($urandom_range(0, 17));
        ro = tbl[idx].opc;
        rf = (ro == 6'h00) ? tbl[idx].fn : 6'($urandom);
      end else begin
        ro = 6'($urandom);
        rf = 6'($urandom);
      end
      if (t % 8 == 0) do_txn(ro, rf, 32'd77, 32'd77, 16'($urandom), int'($urandom_range(0, 2)));
      else do_txn(ro, rf, $urandom, $urandom, 16'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
